// File: rtl/pool_sequencer.sv
// pool_sequencer: window-ordered feature reads, credit-gated
// skid FIFO, engine stream and pooled-result writeback.
module pool_sequencer #(
  parameter int IN_W     = 64,
  parameter int IN_H     = 64,
  parameter int CHANNELS = 30,
  parameter int STRIDE   = 2,
  parameter int MEM_LAT  = 1,
  parameter int DATA_W   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic mem_rd_en,
  output logic [$clog2(IN_W*IN_H*CHANNELS)-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] win_data,
  output logic win_valid,
  output logic win_last,
  input  logic eng_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic res_valid,
  output logic wr_en,
  output logic [$clog2((IN_W/STRIDE)*(IN_H/STRIDE)*CHANNELS)-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  localparam int OW    = IN_W / STRIDE;
  localparam int OH    = IN_H / STRIDE;
  localparam int NRD   = IN_W * IN_H * CHANNELS;
  localparam int NWR   = OW * OH * CHANNELS;
  localparam int RA_W  = $clog2(NRD);
  localparam int WA_W  = $clog2(NWR);
  localparam int RCW   = WA_W + 1;
  localparam int DEPTH = MEM_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int KW    = $clog2(STRIDE) + 1;
  localparam int XW    = $clog2(OW) + 1;
  localparam int YW    = $clog2(OH) + 1;
  localparam int HW    = $clog2(CHANNELS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [HW-1:0] ch_q, ch_d;
  logic [RA_W-1:0] row_q, row_d, win_q, win_d;
  logic [RA_W-1:0] col_q, col_d;
  logic [MEM_LAT-1:0] vld_q, vld_d, tag_q, tag_d;
  logic [DATA_W-1:0] fd_q [DEPTH];
  logic [DATA_W-1:0] fd_d [DEPTH];
  logic [DEPTH-1:0] fl_q, fl_d;
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic [WA_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic wr_en_q, wr_en_d, wl_q, wl_d;
  logic pop, push, k_last, rd_last, credit_ok, res_acc;
  int inflight;

  assign win_valid = (cnt_q != '0);
  assign pop       = win_valid & eng_ready;
  assign push      = vld_q[MEM_LAT-1];
  assign win_data  = fd_q[rp_q];
  assign win_last  = fl_q[rp_q];
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wa_q;
  assign wr_data   = wd_q;
  assign mem_rd_addr = row_q + col_q + RA_W'(kx_q);
  assign k_last = (kx_q == KW'(STRIDE-1)) && (ky_q == KW'(STRIDE-1));
  assign rd_last = k_last && (ox_q == XW'(OW-1)) &&
                   (oy_q == YW'(OH-1)) && (ch_q == HW'(CHANNELS-1));

  // Issue credit: reads in flight plus FIFO occupancy, net of pop.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < MEM_LAT; i++) inflight += int'(vld_q[i]);
    credit_ok = (inflight + int'(cnt_q) - int'(pop)) < DEPTH;
    mem_rd_en = (state_q == RUN) && credit_ok;
  end

  // Window-order address walk using incremental bases.
  always_comb begin
    kx_d = kx_q; ky_d = ky_q; ox_d = ox_q;
    oy_d = oy_q; ch_d = ch_q;
    row_d = row_q; win_d = win_q; col_d = col_q;
    if (state_q == IDLE) begin
      kx_d = '0; ky_d = '0; ox_d = '0; oy_d = '0; ch_d = '0;
      row_d = '0; win_d = '0; col_d = '0;
    end else if (mem_rd_en) begin
      if (kx_q != KW'(STRIDE-1)) begin
        kx_d = kx_q + 1'b1;
      end else begin
        kx_d = '0;
        if (ky_q != KW'(STRIDE-1)) begin
          ky_d = ky_q + 1'b1;
          row_d = row_q + RA_W'(IN_W);
        end else begin
          ky_d = '0;
          row_d = win_q;
          if (ox_q != XW'(OW-1)) begin
            ox_d = ox_q + 1'b1;
            col_d = col_q + RA_W'(STRIDE);
          end else begin
            ox_d = '0;
            col_d = '0;
            win_d = win_q + RA_W'(STRIDE*IN_W);
            row_d = win_q + RA_W'(STRIDE*IN_W);
            if (oy_q != YW'(OH-1)) begin
              oy_d = oy_q + 1'b1;
            end else begin
              oy_d = '0;
              ch_d = ch_q + 1'b1;
            end
          end
        end
      end
    end
  end

  // Latency shift register and skid FIFO.
  always_comb begin
    vld_d = MEM_LAT'({vld_q, mem_rd_en});
    tag_d = MEM_LAT'({tag_q, mem_rd_en & k_last});
    fd_d = fd_q;
    fl_d = fl_q;
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) begin
      fd_d[wp_q] = mem_rd_data;
      fl_d[wp_q] = tag_q[MEM_LAT-1];
      wp_d = (wp_q == PW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
    end
    if (pop) rp_d = (rp_q == PW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Result capture and sequential pooled-write address.
  always_comb begin
    res_acc = res_valid && busy && (rc_q < RCW'(NWR));
    wr_en_d = res_acc;
    wd_d = wd_q;
    wa_d = wa_q;
    rc_d = rc_q;
    wl_d = 1'b0;
    if (res_acc) begin
      wd_d = res_data;
      wa_d = rc_q[WA_W-1:0];
      rc_d = rc_q + 1'b1;
      wl_d = (rc_q == RCW'(NWR-1));
    end
    if (state_q == IDLE) rc_d = '0;
  end

  // Pass control state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (mem_rd_en && rd_last) state_d = DRAIN;
      DRAIN: if (wr_en_q && wl_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kx_q <= '0; ky_q <= '0; ox_q <= '0; oy_q <= '0; ch_q <= '0;
      row_q <= '0; win_q <= '0; col_q <= '0;
      vld_q <= '0; tag_q <= '0;
      for (int i = 0; i < DEPTH; i++) fd_q[i] <= '0;
      fl_q <= '0; rp_q <= '0; wp_q <= '0; cnt_q <= '0;
      rc_q <= '0; wa_q <= '0; wd_q <= '0;
      wr_en_q <= 1'b0; wl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q <= kx_d; ky_q <= ky_d; ox_q <= ox_d;
      oy_q <= oy_d; ch_q <= ch_d;
      row_q <= row_d; win_q <= win_d; col_q <= col_d;
      vld_q <= vld_d; tag_q <= tag_d;
      fd_q <= fd_d;
      fl_q <= fl_d; rp_q <= rp_d; wp_q <= wp_d; cnt_q <= cnt_d;
      rc_q <= rc_d; wa_q <= wa_d; wd_q <= wd_d;
      wr_en_q <= wr_en_d; wl_q <= wl_d;
    end
  end
endmodule

// File: tb/tb_pool_sequencer.sv
// tb_pool_sequencer: directed checks of read order, stream,
// writeback, stalls, restart and reset abort.
module tb_pool_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset, reset2, start, start2;
  logic busy, done, rd_en, win_valid, win_last, wr_en;
  logic [4:0] rd_addr;
  logic [2:0] wr_addr;
  logic [15:0] rd_data = '0, win_data, wr_data, res_data;
  logic eng_ready, res_valid;
  logic busy2, done2, rd_en2, win_valid2, win_last2, wr_en2;
  logic [4:0] rd_addr2;
  logic [2:0] wr_addr2;
  logic [15:0] rd_data2 = '0, win_data2, wr_data2;
  logic eng_ready2 = 1'b0;
  logic manual = 1'b0, man_rv = 1'b0, eng_rv = 1'b0;
  logic [15:0] man_rd = '0, eng_rd = '0;

  assign eng_ready = 1'b1;
  assign res_valid = manual ? man_rv : eng_rv;
  assign res_data  = manual ? man_rd : eng_rd;

  pool_sequencer #(.IN_W(4), .IN_H(4), .CHANNELS(2), .STRIDE(2),
                   .MEM_LAT(2), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .done(done), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr),
    .mem_rd_data(rd_data), .win_data(win_data),
    .win_valid(win_valid), .win_last(win_last),
    .eng_ready(eng_ready), .res_data(res_data),
    .res_valid(res_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data));

  pool_sequencer #(.IN_W(4), .IN_H(4), .CHANNELS(2), .STRIDE(2),
                   .MEM_LAT(3), .DATA_W(16)) dut3 (
    .clk(clk), .reset(reset2), .start(start2), .busy(busy2),
    .done(done2), .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2),
    .mem_rd_data(rd_data2), .win_data(win_data2),
    .win_valid(win_valid2), .win_last(win_last2),
    .eng_ready(eng_ready2), .res_data(16'h0),
    .res_valid(1'b0), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2));

  int base_tbl [16] = '{0, 1, 4, 5, 2, 3, 6, 7,
                        8, 9, 12, 13, 10, 11, 14, 15};

  function automatic logic [15:0] mval(input int a);
    return 16'((a * 40503 + 12345) & 32'hFFFF);
  endfunction

  function automatic int ea(input int i);
    return base_tbl[i % 16] + 16 * (i / 16);
  endfunction

  function automatic int emax(input int w);
    int m = 0;
    for (int k = 0; k < 4; k++)
      if (int'(mval(ea(4 * w + k))) > m) m = int'(mval(ea(4 * w + k)));
    return m;
  endfunction

  int rd_a[$], rd_c[$], pop_d[$], pop_l[$];
  int wr_a[$], wr_d[$], wr_c[$], done_c[$];
  int p2_d[$], p2_l[$];
  logic busy_at [0:1023];
  logic wv_at [0:1023];
  int hist1 [3];
  int hist2 [4];
  int iss2 = 0, np2 = 0, cred2 = 0, max_cred2 = 0;
  logic [15:0] acc = '0, pend_d = '0;
  bit first = 1'b1, pend = 1'b0;

  // Negedge monitor plus memory and engine models.
  always begin
    @(negedge clk);
    if (cyc < 1024) begin
      busy_at[cyc] = busy;
      wv_at[cyc] = win_valid;
    end
    if (rd_en) begin
      rd_a.push_back(int'(rd_addr));
      rd_c.push_back(cyc);
    end
    if (win_valid && eng_ready) begin
      pop_d.push_back(int'(win_data));
      pop_l.push_back(int'(win_last));
      acc = (first || win_data > acc) ? win_data : acc;
      first = 1'b0;
      if (win_last) begin
        pend = 1'b1;
        pend_d = acc;
        first = 1'b1;
      end
    end
    if (wr_en) begin
      wr_a.push_back(int'(wr_addr));
      wr_d.push_back(int'(wr_data));
      wr_c.push_back(cyc);
    end
    if (done) done_c.push_back(cyc);
    if (reset) begin
      first = 1'b1;
      pend = 1'b0;
    end
    cred2 = iss2 - np2;
    if (cred2 > max_cred2) max_cred2 = cred2;
    if (rd_en2) iss2++;
    if (win_valid2 && eng_ready2) begin
      p2_d.push_back(int'(win_data2));
      p2_l.push_back(int'(win_last2));
      np2++;
    end
    @(posedge clk);
    #1;
    hist1[2] = hist1[1]; hist1[1] = hist1[0];
    hist1[0] = int'(rd_addr);
    rd_data = mval(hist1[2]);
    hist2[3] = hist2[2]; hist2[2] = hist2[1];
    hist2[1] = hist2[0]; hist2[0] = int'(rd_addr2);
    rd_data2 = mval(hist2[3]);
    eng_rv = pend;
    eng_rd = pend_d;
    pend = 1'b0;
    eng_ready2 = 1'($urandom_range(0, 1));
  end

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int s0, s1, t, n, na, nw, nd, fw, rc;

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    start = 1'b0; start2 = 1'b0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1'b0; reset2 = 1'b0;
    step(2);

    s0 = cyc;
    start = 1'b1; start2 = 1'b1;
    step(1);
    start = 1'b0; start2 = 1'b0;
    step(10);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(15);
    start = 1'b1;
    for (int i = 0; i < 300 && done_c.size() == 0; i++) step(1);
    chk("done_seen", done_c.size() > 0, 1);
    t = (done_c.size() > 0) ? done_c[0] - 1 : 0;
    for (int i = 0; i < 20 && cyc < t + 4; i++) step(1);
    start = 1'b0;

    n = 0;
    foreach (rd_c[i]) if (rd_c[i] <= t) n++;
    chk("pass1_reads", n, 32);
    chk("first_rd_cycle", rd_c.size() > 0 ? rd_c[0] : -1, s0 + 1);
    for (int i = 0; i < 32 && i < rd_a.size(); i++)
      chk($sformatf("rd_addr[%0d]", i), rd_a[i], ea(i));
    chk("rd_back_to_back", rd_c.size() > 31 ?
        rd_c[31] - rd_c[0] : -1, 31);
    fw = -1;
    for (int c = s0 + 1; c < s0 + 20; c++)
      if (fw < 0 && wv_at[c] === 1'b1) fw = c;
    chk("first_win_valid", fw, s0 + 4);
    chk("pass1_pops", pop_d.size() >= 32, 1);
    for (int i = 0; i < 32 && i < pop_d.size(); i++) begin
      chk($sformatf("elem[%0d]", i), pop_d[i], mval(ea(i)));
      chk($sformatf("last[%0d]", i), pop_l[i], (i % 4) == 3);
    end
    n = 0;
    foreach (wr_c[i]) if (wr_c[i] <= t) n++;
    chk("pass1_writes", n, 8);
    for (int i = 0; i < 8 && i < wr_a.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_a[i], i);
      chk($sformatf("wr_max[%0d]", i), wr_d[i], emax(i));
    end
    chk("last_wr_cycle", wr_c.size() > 7 ? wr_c[7] : -1, t);
    n = 0;
    foreach (done_c[i]) if (done_c[i] <= t + 1) n++;
    chk("done_once", n, 1);
    chk("busy_at_final_wr", busy_at[t], 1);
    chk("busy_at_done", busy_at[t + 1], 0);
    chk("busy_idle_gap", busy_at[t + 2], 0);
    chk("pass2_started", rd_c.size() > 32, 1);
    if (rd_c.size() > 32) begin
      chk("pass2_rd_cycle", rd_c[32], t + 3);
      chk("pass2_rd_addr", rd_a[32], 0);
    end

    step(3);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_win_valid", win_valid, 0);
    chk("abort_wr_en", wr_en, 0);
    step(1);
    reset = 1'b0;
    rc = cyc;
    na = rd_a.size();
    step(6);
    n = 0;
    for (int c = rc; c < rc + 6; c++) if (wv_at[c] !== 1'b0) n++;
    chk("no_stale_win_valid", n, 0);
    chk("no_reads_after_abort", rd_a.size(), na);

    manual = 1'b1;
    nw = wr_a.size();
    man_rv = 1'b1; man_rd = 16'hBEEF;
    step(1);
    man_rv = 1'b0;
    step(3);
    chk("idle_res_ignored", wr_a.size(), nw);

    na = rd_a.size();
    nd = done_c.size();
    s1 = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(40);
    chk("pass3_reads", rd_a.size() - na, 32);
    if (rd_a.size() > na) begin
      chk("pass3_rd_addr", rd_a[na], 0);
      chk("pass3_rd_cycle", rd_c[na], s1 + 1);
    end
    chk("pass3_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      man_rv = 1'b1;
      man_rd = 16'(100 + 3 * i);
      step(1);
    end
    man_rv = 1'b0;
    step(4);
    chk("drain_writes", wr_a.size() - nw, 8);
    for (int i = 0; i < 8 && nw + i < wr_a.size(); i++) begin
      chk($sformatf("drain_addr[%0d]", i), wr_a[nw + i], i);
      chk($sformatf("drain_data[%0d]", i), wr_d[nw + i], 100 + 3 * i);
    end
    if (wr_a.size() >= nw + 8) begin
      chk("drain_consecutive", wr_c[nw + 7] - wr_c[nw], 7);
      chk("drain_done", done_c.size() - nd, 1);
      if (done_c.size() > nd)
        chk("drain_done_cycle", done_c[nd], wr_c[nw + 7] + 1);
    end

    for (int i = 0; i < 400 && p2_d.size() < 32; i++) step(1);
    chk("stall_pops", p2_d.size(), 32);
    for (int i = 0; i < 32 && i < p2_d.size(); i++) begin
      chk($sformatf("stall_elem[%0d]", i), p2_d[i], mval(ea(i)));
      chk($sformatf("stall_last[%0d]", i), p2_l[i], (i % 4) == 3);
    end
    chk("stall_reads", iss2, 32);
    chk("stall_credit_le5", max_cred2 <= 5, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
